// File: rtl/sram_read_engine.sv
`default_nettype none
// ============================================================================
// Module   : sram_read_engine
// Purpose  : Walks one packet's page chain (one page issue every 8 cycles)
//            and re-times the returned halfwords into a gap-free sop/eop
//            stream. Optional macro ECC_CHECK_EN adds per-page ECC checking.
// Revision : 1.0 - initial release
// ============================================================================
module sram_read_engine #(
    parameter int PAGE_AW = 11,
    parameter int LEN_LSB = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_start,
    input  logic [15:0]        rd_head_addr,
    output logic               rd_ready,
    output logic               rd_another_page,
    output logic [PAGE_AW-1:0] rd_page,
    input  logic [15:0]        rd_xfer_data,
    input  logic [15:0]        rd_next_page,
    input  logic [7:0]         rd_ecc_code,
    output logic               out_data_vld,
    output logic [15:0]        out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic               ecc_err,
    output logic [PAGE_AW-1:0] ecc_err_page
);

    localparam int c_LW = 16 - LEN_LSB;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HEAD   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [c_LW-1:0]    r_cnt;
    logic [c_LW-1:0]    r_lc;
    logic [PAGE_AW-1:0] r_next;
    logic [c_LW-1:0]    w_hdr_len;
    logic [c_LW-1:0]    w_lc;
    logic [c_LW:0]      w_next_start;
    logic               w_last;

    // r_cnt is the index of the halfword currently on rd_xfer_data; the
    // length is taken straight from the header while halfword 0 is present.
    always_comb begin
        w_hdr_len    = rd_xfer_data[15:LEN_LSB];
        w_lc         = r_lc;
        if (r_cnt == '0) begin
            w_lc = (w_hdr_len == '0) ? c_LW'(1) : w_hdr_len;
        end
        w_last       = (r_cnt == w_lc - c_LW'(1));
        w_next_start = {1'b0, r_cnt[c_LW-1:3], 3'b000} + (c_LW+1)'(8);
    end

    assign rd_ready = (r_state == c_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_cnt           <= '0;
            r_lc            <= '0;
            r_next          <= '0;
            rd_another_page <= 1'b0;
            rd_page         <= '0;
            out_data_vld    <= 1'b0;
            out_data        <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
        end else begin
            rd_another_page <= 1'b0;
            out_data_vld    <= 1'b0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (rd_start) begin
                        r_state         <= c_HEAD;
                        rd_another_page <= 1'b1;
                        rd_page         <= rd_head_addr[PAGE_AW-1:0];
                    end
                end
                c_HEAD: begin
                    r_state <= c_STREAM;
                    r_cnt   <= '0;
                end
                c_STREAM: begin
                    out_data_vld <= 1'b1;
                    out_data     <= rd_xfer_data;
                    out_sop      <= (r_cnt == '0);
                    out_eop      <= w_last;
                    if (r_cnt == '0) begin
                        r_lc <= w_lc;
                    end
                    if (r_cnt[2:0] == 3'd0) begin
                        r_next <= rd_next_page[PAGE_AW-1:0];
                    end
                    // Issue one cycle early so the next page's data follows slot 7 back-to-back.
                    if ((r_cnt[2:0] == 3'd6) && (w_next_start < {1'b0, w_lc})) begin
                        rd_another_page <= 1'b1;
                        rd_page         <= r_next;
                    end
                    if (w_last) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_LW'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ECC_CHECK_EN
    logic [2:0]         w_slot;
    logic [127:0]       r_buf;
    logic [127:0]       w_buf;
    logic [7:0]         r_code;
    logic [7:0]         w_code;
    logic [7:0]         w_enc;
    logic [PAGE_AW-1:0] r_pg;
    logic [PAGE_AW-1:0] w_pg;
    logic               w_close;
    logic               w_unused;

    // Slot 0 clears the buffer so unwritten tail slots of the last page read as zero.
    always_comb begin
        w_slot = r_cnt[2:0];
        w_buf  = (w_slot == 3'd0) ? '0 : r_buf;
        w_buf[{w_slot, 4'b0000} +: 16] = rd_xfer_data;
        w_code  = (w_slot == 3'd0) ? rd_ecc_code : r_code;
        w_pg    = (w_slot == 3'd0) ? rd_page : r_pg;
        w_close = (r_state == c_STREAM) && ((w_slot == 3'd7) || w_last);
    end

    ecc_encoder u_ecc_encoder (
        .i_data (w_buf),
        .o_code (w_enc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_code       <= '0;
            r_pg         <= '0;
            ecc_err      <= 1'b0;
            ecc_err_page <= '0;
        end else begin
            ecc_err <= 1'b0;
            if (r_state == c_STREAM) begin
                r_buf  <= w_buf;
                r_code <= w_code;
                r_pg   <= w_pg;
                if (w_close && (w_enc != w_code)) begin
                    ecc_err      <= 1'b1;
                    ecc_err_page <= w_pg;
                end
            end
        end
    end

    assign w_unused = ^{rd_head_addr[15:PAGE_AW], rd_next_page[15:PAGE_AW]};
`else
    logic w_unused;

    assign ecc_err      = 1'b0;
    assign ecc_err_page = '0;
    assign w_unused     = ^{rd_head_addr[15:PAGE_AW], rd_next_page[15:PAGE_AW], rd_ecc_code};
`endif

endmodule

`ifdef ECC_CHECK_EN
// ============================================================================
// Module   : ecc_encoder
// Purpose  : 8-bit check code over one 8-halfword page.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_encoder (
    input  logic [127:0] i_data,
    output logic [7:0]   o_code
);
    always_comb begin
        o_code = '0;
        for (int h = 0; h < 8; h++) begin
            o_code = o_code ^ i_data[16*h +: 8]
                   ^ {i_data[16*h+8 +: 7], i_data[16*h+15]};
        end
    end
endmodule
`endif

`default_nettype wire

// File: tb/tb_sram_read_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_read_engine
// Purpose  : Directed self-checking bench for sram_read_engine with a
//            behavioural SRAM-interface responder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_read_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_start;
    logic [15:0] rd_head_addr;
    logic        rd_ready;
    logic        rd_another_page;
    logic [10:0] rd_page;
    logic [15:0] rd_xfer_data;
    logic [15:0] rd_next_page;
    logic [7:0]  rd_ecc_code;
    logic        out_data_vld;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        ecc_err;
    logic [10:0] ecc_err_page;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          iss_cyc[$];
    logic [10:0] iss_pg[$];
    int          vld_cyc[$];
    logic [15:0] vld_dat[$];
    int          sop_cyc[$];
    int          eop_cyc[$];

    logic [15:0] hw0 = 16'h0;
    int          pages_seen = 0;

    sram_read_engine #(.PAGE_AW(11), .LEN_LSB(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_start        (rd_start),
        .rd_head_addr    (rd_head_addr),
        .rd_ready        (rd_ready),
        .rd_another_page (rd_another_page),
        .rd_page         (rd_page),
        .rd_xfer_data    (rd_xfer_data),
        .rd_next_page    (rd_next_page),
        .rd_ecc_code     (rd_ecc_code),
        .out_data_vld    (out_data_vld),
        .out_data        (out_data),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .ecc_err         (ecc_err),
        .ecc_err_page    (ecc_err_page)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] chain_next(input logic [10:0] p);
        if (p == 11'h012)      return 11'h345;
        else if (p == 11'h345) return 11'h0FF;
        else                   return p + 11'd1;
    endfunction

    // Expected halfword j of a packet whose pages follow chain_next from head.
    function automatic logic [15:0] exp_hw(input logic [10:0] head, input int j, input logic [15:0] h0);
        logic [10:0] p;
        logic [2:0]  o;
        p = head;
        for (int k = 0; k < j / 8; k++) p = chain_next(p);
        o = 3'(j % 8);
        if (j == 0) return h0;
        return {p[7:0], 5'b00000, o};
    endfunction

    // SRAM interface model: page data and next link one cycle after each issue.
    initial begin : responder
        logic        pend;
        logic [10:0] pend_pg;
        logic [10:0] cur;
        int          off;
        int          pidx;
        pend = 1'b0; pend_pg = '0; cur = '0; off = 0; pidx = 1;
        rd_xfer_data = '0; rd_next_page = '0; rd_ecc_code = '0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                cur  = pend_pg;
                off  = 0;
                pidx = pages_seen;
                pages_seen++;
                rd_next_page = {5'b10101, chain_next(cur)};
            end else begin
                off++;
            end
            rd_xfer_data = (pidx == 0 && off == 0) ? hw0 : {cur[7:0], 5'b00000, 3'(off % 8)};
            pend    = rd_another_page;
            pend_pg = rd_page;
        end
    end

    initial begin : recorder
        forever begin
            @(posedge clk); #1;
            if (rd_another_page) begin iss_cyc.push_back(cyc + 1); iss_pg.push_back(rd_page); end
            if (out_data_vld)    begin vld_cyc.push_back(cyc + 1); vld_dat.push_back(out_data); end
            if (out_sop)         sop_cyc.push_back(cyc + 1);
            if (out_eop)         eop_cyc.push_back(cyc + 1);
        end
    end

    task automatic clear_q();
        iss_cyc.delete(); iss_pg.delete(); vld_cyc.delete();
        vld_dat.delete(); sop_cyc.delete(); eop_cyc.delete();
    endtask

    task automatic wait_cycle(input int t);
        while (cyc + 1 < t) begin @(posedge clk); #1; end
    endtask

    task automatic start_pkt(input logic [15:0] head, input logic [15:0] h, output int n);
        pages_seen   = 0;
        hw0          = h;
        rd_start     = 1'b1;
        rd_head_addr = head;
        @(posedge clk); #1;
        n        = cyc;
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_start = 1'b0; rd_head_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
        n_cmp++; if ({rd_another_page, out_data_vld, out_sop, out_eop, ecc_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_pulses got %b want 00000", {rd_another_page, out_data_vld, out_sop, out_eop, ecc_err}); end
        n_cmp++; if ({rd_page, out_data, ecc_err_page} !== 38'h0) begin
            n_bad++; $display("FAIL reset_values got %h/%h/%h want 0", rd_page, out_data, ecc_err_page); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_page();
        int n, bad;
        clear_q();
        start_pkt(16'h0012, 16'h0405, n);
        wait_cycle(n + 10);
        n_cmp++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_busy got %b want 0", rd_ready); end
        wait_cycle(n + 11);
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_done got %b want 1", rd_ready); end
        n_cmp++; if (iss_cyc.size() != 1 || iss_cyc[0] != n + 1 || iss_pg[0] !== 11'h012) begin
            n_bad++; $display("FAIL single_issue got %0d pulses first@%0d pg %h want 1 @%0d pg 012",
                              iss_cyc.size(), iss_cyc.size() ? iss_cyc[0] - n : -1, iss_pg.size() ? iss_pg[0] : 11'h0, 1); end
        bad = 0;
        for (int j = 0; j < vld_cyc.size(); j++)
            if (vld_cyc[j] != n + 3 + j || vld_dat[j] !== exp_hw(11'h012, j, 16'h0405)) bad++;
        n_cmp++; if (vld_cyc.size() != 8 || bad != 0) begin
            n_bad++; $display("FAIL single_data got %0d valid (%0d bad) want 8 (0 bad)", vld_cyc.size(), bad); end
        n_cmp++; if (sop_cyc.size() != 1 || eop_cyc.size() != 1 || sop_cyc[0] != n + 3 || eop_cyc[0] != n + 10) begin
            n_bad++; $display("FAIL single_sop_eop got %0d/%0d markers want sop@+3 eop@+10", sop_cyc.size(), eop_cyc.size()); end
    endtask

    task automatic test_three_pages();
        int n, bad;
        logic [10:0] pg[3];
        pg[0] = 11'h012; pg[1] = 11'h345; pg[2] = 11'h0FF;
        clear_q();
        start_pkt(16'h8012, 16'h0A03, n);
        // rd_start while busy must be ignored
        wait_cycle(n + 5);
        rd_start = 1'b1; rd_head_addr = 16'h0777;
        @(posedge clk); #1;
        rd_start = 1'b0;
        wait_cycle(n + 26);
        bad = 0;
        for (int k = 0; k < iss_cyc.size(); k++)
            if (k > 2 || iss_cyc[k] != n + 1 + 8 * k || iss_pg[k] !== pg[k]) bad++;
        n_cmp++; if (iss_cyc.size() != 3 || bad != 0) begin
            n_bad++; $display("FAIL three_issue got %0d pulses (%0d bad) want 3 (0 bad)", iss_cyc.size(), bad); end
        bad = 0;
        for (int j = 0; j < vld_cyc.size(); j++)
            if (vld_cyc[j] != n + 3 + j || vld_dat[j] !== exp_hw(11'h012, j, 16'h0A03)) bad++;
        n_cmp++; if (vld_cyc.size() != 20 || bad != 0) begin
            n_bad++; $display("FAIL three_data got %0d valid (%0d bad) want 20 (0 bad)", vld_cyc.size(), bad); end
        n_cmp++; if (eop_cyc.size() != 1 || eop_cyc[0] != n + 22) begin
            n_bad++; $display("FAIL three_eop got %0d eops first@+%0d want 1 @+22",
                              eop_cyc.size(), eop_cyc.size() ? eop_cyc[0] - n : -1); end
    endtask

    task automatic test_zero_len();
        int n;
        clear_q();
        start_pkt(16'h0012, 16'h0007, n);
        wait_cycle(n + 4);
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %b want 1", rd_ready); end
        wait_cycle(n + 12);
        n_cmp++; if (iss_cyc.size() != 1 || iss_cyc[0] != n + 1) begin
            n_bad++; $display("FAIL zero_issue got %0d pulses want 1", iss_cyc.size()); end
        n_cmp++; if (vld_cyc.size() != 1 || vld_cyc[0] != n + 3 || vld_dat[0] !== 16'h0007) begin
            n_bad++; $display("FAIL zero_data got %0d valid want 1 @+3 data 0007", vld_cyc.size()); end
        n_cmp++; if (sop_cyc.size() != 1 || eop_cyc.size() != 1 || sop_cyc[0] != n + 3 || eop_cyc[0] != n + 3) begin
            n_bad++; $display("FAIL zero_sop_eop got %0d/%0d markers want both @+3", sop_cyc.size(), eop_cyc.size()); end
    endtask

    task automatic test_max_len();
        int n, bad;
        logic [10:0] p;
        clear_q();
        start_pkt(16'h0012, 16'hFF80, n);
        wait_cycle(n + 514);
        n_cmp++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL max_ready got %b want 1", rd_ready); end
        wait_cycle(n + 530);
        bad = 0; p = 11'h012;
        for (int k = 0; k < iss_cyc.size(); k++) begin
            if (iss_cyc[k] != n + 1 + 8 * k || iss_pg[k] !== p) bad++;
            p = chain_next(p);
        end
        n_cmp++; if (iss_cyc.size() != 64 || bad != 0) begin
            n_bad++; $display("FAIL max_issue got %0d pulses (%0d bad) want 64 (0 bad)", iss_cyc.size(), bad); end
        bad = 0;
        for (int j = 0; j < vld_cyc.size(); j++)
            if (vld_cyc[j] != n + 3 + j || vld_dat[j] !== exp_hw(11'h012, j, 16'hFF80)) bad++;
        n_cmp++; if (vld_cyc.size() != 511 || bad != 0) begin
            n_bad++; $display("FAIL max_data got %0d valid (%0d bad) want 511 (0 bad)", vld_cyc.size(), bad); end
        n_cmp++; if (eop_cyc.size() != 1 || eop_cyc[0] != n + 513) begin
            n_bad++; $display("FAIL max_eop got %0d eops want 1 @+513", eop_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int n, n2, bad;
        clear_q();
        start_pkt(16'h0012, 16'h0A03, n);
        wait_cycle(n + 12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (rd_ready !== 1'b1 || out_data_vld !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_idle got ready %b vld %b want 1 0", rd_ready, out_data_vld); end
        start_pkt(16'h0200, 16'h0405, n2);
        n_cmp++; if (n2 != n + 13) begin n_bad++; $display("FAIL rstmid_restart got edge +%0d want +13", n2 - n); end
        wait_cycle(n2 + 14);
        n_cmp++; if (iss_cyc.size() != 3 || iss_cyc[0] != n + 1 || iss_cyc[1] != n + 9 || iss_cyc[2] != n2 + 1
                     || iss_pg[1] !== 11'h345 || iss_pg[2] !== 11'h200) begin
            n_bad++; $display("FAIL rstmid_issue got %0d pulses want 3 (+1,+9,+14)", iss_cyc.size()); end
        bad = 0;
        for (int j = 0; j < vld_cyc.size(); j++) begin
            if (j < 10) begin
                if (vld_cyc[j] != n + 3 + j || vld_dat[j] !== exp_hw(11'h012, j, 16'h0A03)) bad++;
            end else begin
                if (vld_cyc[j] != n2 + 3 + (j - 10) || vld_dat[j] !== exp_hw(11'h200, j - 10, 16'h0405)) bad++;
            end
        end
        n_cmp++; if (vld_cyc.size() != 18 || bad != 0) begin
            n_bad++; $display("FAIL rstmid_data got %0d valid (%0d bad) want 18 (0 bad)", vld_cyc.size(), bad); end
        n_cmp++; if (eop_cyc.size() != 1 || eop_cyc[0] != n2 + 10 || sop_cyc.size() != 2) begin
            n_bad++; $display("FAIL rstmid_markers got %0d eop %0d sop want 1 eop @+10, 2 sop", eop_cyc.size(), sop_cyc.size()); end
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_three_pages();
        test_zero_len();
        test_max_len();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
